multi_digit_bcd_sync_cntr: RTL and testbench

MULTI_DIGIT_BCD_SYNC_CNTR -- requirements
Module: multi_digit_bcd_sync_cntr

---
 rtl/multi_digit_bcd_sync_cntr.sv | 81 ++++++++
 tb/tb_multi_digit_bcd_sync_cntr.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_bcd_sync_cntr.sv
// Cascaded NDIGITS-digit BCD up/down counter with synchronous load and a sticky wrap flag.
// Define MULTI_DIGIT_BCD_CNTR_SAT_EN to saturate at terminal count instead of wrapping.
module multi_digit_bcd_sync_cntr #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cnt_en,
  input  logic                   up,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   I,
  output logic [4*NDIGITS-1:0]   count,
  output logic                   carry,
  output logic                   ovf
);

  logic [4*NDIGITS-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  // lo9[k]/lo0[k]: every digit below k is 9 / 0; index NDIGITS covers the whole word
  logic [NDIGITS:0]     lo9, lo0;
  logic                 tc;
  logic [3:0]           dig;

  always_comb begin
    lo9 = '0;
    lo0 = '0;
    lo9[0] = 1'b1;
    lo0[0] = 1'b1;
    for (int k = 0; k < NDIGITS; k++) begin
      lo9[k+1] = lo9[k] & (count_q[4*k +: 4] == 4'd9);
      lo0[k+1] = lo0[k] & (count_q[4*k +: 4] == 4'd0);
    end
    tc = up ? lo9[NDIGITS] : lo0[NDIGITS];
  end

  assign carry = cnt_en & tc;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    dig     = '0;
    if (load) begin
      for (int k = 0; k < NDIGITS; k++)
        count_d[4*k +: 4] = (I[4*k +: 4] > 4'd9) ? 4'd0 : I[4*k +: 4];
      ovf_d = 1'b0;
    end else if (cnt_en) begin
      if (tc) begin
        ovf_d = 1'b1;
`ifdef MULTI_DIGIT_BCD_CNTR_SAT_EN
        count_d = count_q;
`else
        for (int k = 0; k < NDIGITS; k++)
          count_d[4*k +: 4] = up ? 4'd0 : 4'd9;
`endif
      end else begin
        // Each digit steps when all lower digits sit at their roll point
        for (int k = 0; k < NDIGITS; k++) begin
          dig = count_q[4*k +: 4];
          if (up && lo9[k])
            count_d[4*k +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
          else if (!up && lo0[k])
            count_d[4*k +: 4] = (dig == 4'd0 || dig > 4'd9) ? 4'd9 : dig - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_multi_digit_bcd_sync_cntr.sv
// Bench for multi_digit_bcd_sync_cntr: 2-digit and 4-digit instances share control inputs;
// an integer-valued model feeds a scoreboard queue, plus a directed vector table.
module tb_multi_digit_bcd_sync_cntr;

  logic        clk = 1'b0;
  logic        rst = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b0;
  logic [7:0]  i2 = '0;
  logic [15:0] i4 = '0;
  logic [7:0]  count2;
  logic [15:0] count4;
  logic        carry2, carry4, ovf2, ovf4;

  always #5 clk = ~clk;

  multi_digit_bcd_sync_cntr #(.NDIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_en(en), .up(up), .load(ld), .I(i2),
    .count(count2), .carry(carry2), .ovf(ovf2));

  multi_digit_bcd_sync_cntr #(.NDIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .cnt_en(en), .up(up), .load(ld), .I(i4),
    .count(count4), .carry(carry4), .ovf(ovf4));

  typedef struct {
    bit r, l, e, u;
    logic [7:0] i;
    logic [7:0] ec;
    bit eo, ecar, cc;
  } vec_t;

  typedef struct {
    logic [7:0]  c2;
    bit          o2;
    logic [15:0] c4;
    bit          o4;
    bit          tb;
    logic [7:0]  tc;
    bit          to;
  } exp_t;

  exp_t q[$];
  vec_t tbl[16];
  int   n_chk = 0, n_fail = 0;
  int   m2 = 0, m4 = 0;
  bit   o2 = 0, o4 = 0, known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [31:0] v, input int n);
    int r = 0;
    logic [3:0] nib;
    for (int d = n - 1; d >= 0; d--) begin
      nib = v[4*d +: 4];
      r = r * 10 + ((nib > 4'd9) ? 0 : int'(nib));
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int x, input int n);
    logic [31:0] r = '0;
    for (int d = 0; d < n; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic mstep(inout int v, inout bit o, input int mx, input int n,
                       input bit r, l, e, u, input logic [31:0] i);
    if (r) begin
      v = 0; o = 0;
    end else if (l) begin
      v = bcd2int(i, n); o = 0;
    end else if (e) begin
      if (u) begin
        if (v == mx) begin
          o = 1;
`ifdef MULTI_DIGIT_BCD_CNTR_SAT_EN
          v = mx;
`else
          v = 0;
`endif
        end else v = v + 1;
      end else begin
        if (v == 0) begin
          o = 1;
`ifdef MULTI_DIGIT_BCD_CNTR_SAT_EN
          v = 0;
`else
          v = mx;
`endif
        end else v = v - 1;
      end
    end
  endtask

  task automatic drive(input bit r, l, e, u, input logic [7:0] x2, input logic [15:0] x4,
                       input bit tb, input logic [7:0] tec, input bit teo, tecar, tcc);
    exp_t ex;
    @(negedge clk);
    rst = r; ld = l; en = e; up = u; i2 = x2; i4 = x4;
    #1;
    if (known) begin
      chk("carry2", 32'(carry2), 32'(e && (u ? m2 == 99 : m2 == 0)));
      chk("carry4", 32'(carry4), 32'(e && (u ? m4 == 9999 : m4 == 0)));
    end
    if (tb && tcc) chk("tbl_carry", 32'(carry2), 32'(tecar));
    mstep(m2, o2, 99, 2, r, l, e, u, 32'(x2));
    mstep(m4, o4, 9999, 4, r, l, e, u, 32'(x4));
    known = known | r | l;
    ex = '{c2: 8'(int2bcd(m2, 2)), o2: o2, c4: 16'(int2bcd(m4, 4)), o4: o4,
           tb: tb, tc: tec, to: teo};
    q.push_back(ex);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk("count2", 32'(count2), 32'(ex.c2));
    chk("ovf2",   32'(ovf2),   32'(ex.o2));
    chk("count4", 32'(count4), 32'(ex.c4));
    chk("ovf4",   32'(ovf4),   32'(ex.o4));
    if (ex.tb) begin
      chk("tbl_count", 32'(count2), 32'(ex.tc));
      chk("tbl_ovf",   32'(ovf2),   32'(ex.to));
    end
  endtask

  initial begin
    //          r  l  e  u  I      count  ovf carry chk_carry
    tbl[0]  = '{1, 1, 0, 0, 8'h55, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 8'h09, 8'h09, 0, 0, 1};
    tbl[2]  = '{0, 0, 1, 1, 8'h00, 8'h10, 0, 0, 1};
    tbl[3]  = '{0, 0, 1, 1, 8'h00, 8'h11, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 1, 8'h99, 8'h99, 0, 0, 1};
`ifdef MULTI_DIGIT_BCD_CNTR_SAT_EN
    tbl[5]  = '{0, 0, 1, 1, 8'h00, 8'h99, 1, 1, 1};
    tbl[6]  = '{0, 0, 0, 1, 8'h00, 8'h99, 1, 0, 1};
    tbl[7]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 1};
    tbl[9]  = '{0, 0, 1, 1, 8'h00, 8'h01, 1, 0, 1};
`else
    tbl[5]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 1, 1};
    tbl[6]  = '{0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1};
    tbl[7]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 8'h99, 1, 1, 1};
    tbl[9]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 1, 1};
`endif
    tbl[10] = '{0, 1, 1, 1, 8'hA7, 8'h07, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 8'h3F, 8'h30, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 0, 8'h00, 8'h29, 0, 0, 1};
    tbl[13] = '{1, 1, 1, 1, 8'h99, 8'h00, 0, 0, 1};
    tbl[14] = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 1};
    tbl[15] = '{0, 0, 1, 1, 8'h00, 8'h01, 0, 0, 1};

    foreach (tbl[n])
      drive(tbl[n].r, tbl[n].l, tbl[n].e, tbl[n].u, tbl[n].i, {tbl[n].i, tbl[n].i},
            1'b1, tbl[n].ec, tbl[n].eo, tbl[n].ecar, tbl[n].cc);

    // 4-digit cascade: 0999 -> 1000 -> 0999 in single clocks
    drive(0, 1, 0, 0, 8'h00, 16'h0999, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 1, 1, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0);
    chk("d4_0999_up", 32'(count4), 32'h1000);
    drive(0, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0);
    chk("d4_1000_dn", 32'(count4), 32'h0999);

    // 4-digit terminal count both directions
    drive(0, 1, 0, 0, 8'h00, 16'h9999, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 1, 1, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 0, 1, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0);
    drive(0, 1, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      bit r, l, e, u;
      logic [7:0]  x2;
      logic [15:0] x4;
      r = ($urandom % 25) == 0;
      l = ($urandom % 6) == 0;
      e = ($urandom % 4) != 0;
      u = $urandom % 2;
      x2 = 8'($urandom);
      x4 = 16'($urandom);
      case ($urandom % 6)
        0: begin x2 = 8'h99; x4 = 16'h9999; end
        1: begin x2 = 8'h00; x4 = 16'h0000; end
        2: begin x2 = 8'h98; x4 = 16'h9989; end
        3: begin x2 = 8'h01; x4 = 16'h1000; end
        default: ;
      endcase
      drive(r, l, e, u, x2, x4, 0, 8'h00, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
